// File: rtl/bitlogic_pipe_if.sv
// Handshake and data bundle of the pipelined bitwise-logic unit.
// The slave modport is the unit itself; the master modport is whatever
// sits around it (operand fetch on the input side, result mux on the output side).
interface bitlogic_pipe_if #(
  parameter int WIDTH = 16
);
  // Issue side
  logic             inValid;
  logic             inReady;
  logic [2:0]       opcode;
  logic             chain;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;

  // Result side
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic [3:0]       statusOut;
  logic             parity;

  modport slave (
    input  inValid, opcode, chain, operand1, operand2, outReady,
    output inReady, outValid, result, statusOut, parity
  );

  modport master (
    output inValid, opcode, chain, operand1, operand2, outReady,
    input  inReady, outValid, result, statusOut, parity
  );
endinterface

// File: rtl/bitlogic_pipe.sv
// Pipelined bitwise-logic unit: eight logic operations with an accumulator
// chain mode, NZCV-style status word and result parity. Everything is computed
// at issue and captured in stage 1; later stages only delay it. A single
// global stall (output valid but not accepted) freezes every stage and the
// accumulator, so valid/ready behaves like a plain elastic pipeline.
module bitlogic_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  bitlogic_pipe_if.slave io
);

  // Status bit positions shared with the rest of the ALU (N Z C V, MSB first).
  localparam int ST_NEG      = 3;
  localparam int ST_ZERO     = 2;
  localparam int ST_CARRY    = 1;
  localparam int ST_OVERFLOW = 0;

  // Opcode encodings.
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  // The eight logic operations; operand b is ignored for NOT.
  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      OP_NOT:  r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Odd parity of a result word: 1 when the number of set bits is odd.
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Status word of a logic result; carry and overflow never set for logic ops.
  function automatic logic [3:0] status_of(input logic [WIDTH-1:0] v);
    logic [3:0] s;
    s              = 4'b0000;
    s[ST_NEG]      = v[WIDTH-1];
    s[ST_ZERO]     = (v == {WIDTH{1'b0}});
    s[ST_CARRY]    = 1'b0;
    s[ST_OVERFLOW] = 1'b0;
    return s;
  endfunction

  // Pipeline state, index 0 is stage 1, index STAGES-1 drives the outputs.
  logic             valid_r  [STAGES];
  logic [WIDTH-1:0] result_r [STAGES];
  logic [3:0]       status_r [STAGES];
  logic             parity_r [STAGES];
  logic [WIDTH-1:0] acc_r;

  logic             stall_s;
  logic             fire_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] calc_result_s;
  logic [3:0]       calc_status_s;
  logic             calc_parity_s;

  // Handshake: stall only when the last stage holds a result nobody takes.
  // inReady deliberately does not look at inValid.
  always_comb begin
    stall_s = 1'b0;
    fire_s  = 1'b0;
    if (valid_r[STAGES-1] && !io.outReady) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
    if (io.inValid && !stall_s) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
  end

  // Issue-time datapath: pick the effective A operand and compute result/flags.
  always_comb begin
    op_a_s = io.operand1;
    if (io.chain) begin
      op_a_s = acc_r;
    end else begin
      op_a_s = io.operand1;
    end
    calc_result_s = logic_op(io.opcode, op_a_s, io.operand2);
    calc_status_s = status_of(calc_result_s);
    calc_parity_s = parity_of(calc_result_s);
  end

  // Accumulator follows every issued result so chained ops never see a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (fire_s) begin
      acc_r <= calc_result_s;
    end
  end

  // Stage 1 capture: valid tracks fire so bubbles travel as invalid entries;
  // data only changes on fire so an idle output keeps its last contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r[0]  <= 1'b0;
      result_r[0] <= '0;
      status_r[0] <= 4'b0000;
      parity_r[0] <= 1'b0;
    end else if (!stall_s) begin
      valid_r[0] <= fire_s;
      if (fire_s) begin
        result_r[0] <= calc_result_s;
        status_r[0] <= calc_status_s;
        parity_r[0] <= calc_parity_s;
      end
    end
  end

  // Delay stages 2..STAGES: plain shift, frozen as a whole during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < STAGES; k++) begin
        valid_r[k]  <= 1'b0;
        result_r[k] <= '0;
        status_r[k] <= 4'b0000;
        parity_r[k] <= 1'b0;
      end
    end else if (!stall_s) begin
      for (int k = 1; k < STAGES; k++) begin
        valid_r[k]  <= valid_r[k-1];
        result_r[k] <= result_r[k-1];
        status_r[k] <= status_r[k-1];
        parity_r[k] <= parity_r[k-1];
      end
    end
  end

  // Outputs come straight from the last stage registers.
  assign io.inReady   = !stall_s;
  assign io.outValid  = valid_r[STAGES-1];
  assign io.result    = result_r[STAGES-1];
  assign io.statusOut = status_r[STAGES-1];
  assign io.parity    = parity_r[STAGES-1];

endmodule

// File: tb/tb_bitlogic_pipe.sv
// Bench for bitlogic_pipe: an 8-bit/2-stage unit exercised with a table of
// hand-computed vectors plus backpressure and reset sequences, and two 32-bit
// units (1 and 4 stages) driven with random ops and stalls against a
// reference model of the logic ops and accumulator.
module tb_bitlogic_pipe;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 8-bit, 2-stage unit ----------------
  bitlogic_pipe_if #(.WIDTH(8)) if8 ();
  bitlogic_pipe #(.WIDTH(8), .STAGES(2)) dut8 (.clk(clk), .rst_n(rst_n), .io(if8));

  // ---------------- 32-bit units, STAGES 1 and 4 ----------------
  bitlogic_pipe_if #(.WIDTH(32)) if1 ();
  bitlogic_pipe_if #(.WIDTH(32)) if4 ();
  bitlogic_pipe #(.WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .io(if1));
  bitlogic_pipe #(.WIDTH(32), .STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .io(if4));

  localparam int STG [2] = '{1, 4};

  logic        rv [2];
  logic        rr [2];
  logic        rc [2];
  logic [2:0]  ro [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic        w_ready [2];
  logic        w_valid [2];
  logic [31:0] w_res   [2];
  logic [3:0]  w_st    [2];
  logic        w_par   [2];
  logic [31:0] acc_m   [2];

  assign if1.inValid  = rv[0];
  assign if1.outReady = rr[0];
  assign if1.chain    = rc[0];
  assign if1.opcode   = ro[0];
  assign if1.operand1 = ra[0];
  assign if1.operand2 = rb[0];
  assign if4.inValid  = rv[1];
  assign if4.outReady = rr[1];
  assign if4.chain    = rc[1];
  assign if4.opcode   = ro[1];
  assign if4.operand1 = ra[1];
  assign if4.operand2 = rb[1];
  assign w_ready[0] = if1.inReady;
  assign w_valid[0] = if1.outValid;
  assign w_res[0]   = if1.result;
  assign w_st[0]    = if1.statusOut;
  assign w_par[0]   = if1.parity;
  assign w_ready[1] = if4.inReady;
  assign w_valid[1] = if4.outValid;
  assign w_res[1]   = if4.result;
  assign w_st[1]    = if4.statusOut;
  assign w_par[1]   = if4.parity;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference logic ops for the 32-bit units.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return ~a;
    endcase
  endfunction

  // Expected status {N, Z, C, V} for a 32-bit result.
  function automatic logic [3:0] ref_st(input logic [31:0] v);
    return {v[31], (v == 32'd0), 1'b0, 1'b0};
  endfunction

  typedef struct {
    logic [2:0] op;
    logic       ch;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] st;
    logic       par;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  typedef struct {
    logic [31:0] res;
    int          issue;
  } exp_t;

  // Random traffic on one 32-bit unit; stalls=0 keeps outReady high so the
  // exact issue-to-output latency can be checked.
  task automatic rand_run(input int d, input int cycles, input bit stalls);
    exp_t        q [$];
    exp_t        e;
    logic        exp_rdy;
    logic [31:0] a_eff;
    for (int c = 0; c < cycles + 20; c++) begin
      @(negedge clk);
      rr[d] = (c >= cycles) ? 1'b1 : (stalls ? ($urandom_range(0, 3) != 0) : 1'b1);
      rv[d] = (c < cycles) ? ($urandom_range(0, 3) != 0) : 1'b0;
      ro[d] = 3'($urandom_range(0, 7));
      rc[d] = 1'($urandom_range(0, 1));
      ra[d] = $urandom();
      rb[d] = $urandom();
      #1;
      exp_rdy = !(w_valid[d] && !rr[d]);
      check("rand_inready", 64'(w_ready[d]), 64'(exp_rdy));
      if (w_valid[d]) begin
        if (q.size() == 0) begin
          check("rand_spurious_out", 64'(1), 64'(0));
        end else begin
          check("rand_result", 64'(w_res[d]), 64'(q[0].res));
          check("rand_status", 64'(w_st[d]), 64'(ref_st(q[0].res)));
          check("rand_parity", 64'(w_par[d]), 64'(^q[0].res));
          if (!stalls)
            check("rand_latency", 64'(c - q[0].issue), 64'(STG[d]));
          else
            check("rand_latency_min", 64'(c - q[0].issue >= STG[d]), 64'(1));
          if (rr[d]) void'(q.pop_front());
        end
      end
      if (rv[d] && exp_rdy) begin
        a_eff   = rc[d] ? acc_m[d] : ra[d];
        e.res   = ref_op(ro[d], a_eff, rb[d]);
        e.issue = c;
        q.push_back(e);
        acc_m[d] = e.res;
      end
    end
    check("rand_drained", 64'(q.size()), 64'(0));
  endtask

  // Watchdog so a wedged run still terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    // Vectors: op, chain, operand1, operand2, result, {N,Z,C,V}, parity
    vecs[0]  = '{3'b000, 1'b0, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0}; // AND
    vecs[1]  = '{3'b010, 1'b0, 8'hAA, 8'hAA, 8'h00, 4'b0100, 1'b0}; // XOR -> zero
    vecs[2]  = '{3'b011, 1'b0, 8'hFF, 8'h80, 8'h7F, 4'b0000, 1'b1}; // NAND
    vecs[3]  = '{3'b111, 1'b0, 8'h7F, 8'h12, 8'h80, 4'b1000, 1'b1}; // NOT -> neg
    vecs[4]  = '{3'b001, 1'b0, 8'h0F, 8'h00, 8'h0F, 4'b0000, 1'b0}; // OR
    vecs[5]  = '{3'b000, 1'b1, 8'hFF, 8'h3C, 8'h0C, 4'b0000, 1'b0}; // chained AND
    vecs[6]  = '{3'b110, 1'b1, 8'hFF, 8'h04, 8'h08, 4'b0000, 1'b1}; // chained ANDN
    vecs[7]  = '{3'b100, 1'b0, 8'h0F, 8'hF0, 8'h00, 4'b0100, 1'b0}; // NOR
    vecs[8]  = '{3'b101, 1'b0, 8'h55, 8'h0F, 8'hA5, 4'b1000, 1'b0}; // XNOR
    vecs[9]  = '{3'b001, 1'b1, 8'h00, 8'h01, 8'hA5, 4'b1000, 1'b0}; // chained OR
    vecs[10] = '{3'b111, 1'b1, 8'hFF, 8'hFF, 8'h5A, 4'b0000, 1'b0}; // chained NOT

    rst_n = 1'b0;
    if8.inValid = 1'b0; if8.outReady = 1'b1; if8.chain = 1'b0;
    if8.opcode = 3'b000; if8.operand1 = 8'h00; if8.operand2 = 8'h00;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rr[d] = 1'b1; rc[d] = 1'b0; ro[d] = 3'b000;
      ra[d] = 32'd0; rb[d] = 32'd0; acc_m[d] = 32'd0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outvalid", 64'(if8.outValid), 64'(0));
    check("rst_result", 64'(if8.result), 64'(0));
    check("rst_status", 64'(if8.statusOut), 64'(0));
    check("rst_parity", 64'(if8.parity), 64'(0));
    check("rst_outvalid32", 64'(if4.outValid), 64'(0));
    rst_n = 1'b1;
    check("rst_inready", 64'(if8.inReady), 64'(1));

    // Table-driven back-to-back issue, output checked exactly two cycles later
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check("vec_valid", 64'(if8.outValid), 64'(1));
        check("vec_result", 64'(if8.result), 64'(vecs[i-2].res));
        check("vec_status", 64'(if8.statusOut), 64'(vecs[i-2].st));
        check("vec_parity", 64'(if8.parity), 64'(vecs[i-2].par));
      end else begin
        check("vec_latency_idle", 64'(if8.outValid), 64'(0));
      end
      if (i < NV) begin
        if8.inValid  = 1'b1;
        if8.opcode   = vecs[i].op;
        if8.chain    = vecs[i].ch;
        if8.operand1 = vecs[i].a;
        if8.operand2 = vecs[i].b;
      end else begin
        if8.inValid = 1'b0;
      end
    end

    // Backpressure: fill both stages, third op must wait for the release
    @(negedge clk);
    check("bp_empty", 64'(if8.outValid), 64'(0));
    if8.outReady = 1'b0;
    if8.inValid = 1'b1; if8.chain = 1'b0;
    if8.opcode = 3'b001; if8.operand1 = 8'h01; if8.operand2 = 8'h02;   // -> 03
    @(negedge clk);
    if8.opcode = 3'b010; if8.operand1 = 8'h0F; if8.operand2 = 8'h01;   // -> 0E
    @(negedge clk);
    if8.opcode = 3'b000; if8.operand1 = 8'hFF; if8.operand2 = 8'h55;   // -> 55
    #1;
    check("bp_inready_low", 64'(if8.inReady), 64'(0));
    check("bp_valid", 64'(if8.outValid), 64'(1));
    check("bp_result", 64'(if8.result), 64'(8'h03));
    repeat (2) @(negedge clk);
    check("bp_inready_hold", 64'(if8.inReady), 64'(0));
    check("bp_result_hold", 64'(if8.result), 64'(8'h03));
    if8.outReady = 1'b1;
    #1;
    check("bp_inready_release", 64'(if8.inReady), 64'(1));
    @(negedge clk);
    if8.inValid = 1'b0;
    check("bp_out2_valid", 64'(if8.outValid), 64'(1));
    check("bp_out2", 64'(if8.result), 64'(8'h0E));
    @(negedge clk);
    check("bp_out3_valid", 64'(if8.outValid), 64'(1));
    check("bp_out3", 64'(if8.result), 64'(8'h55));
    check("bp_out3_par", 64'(if8.parity), 64'(0));
    @(negedge clk);
    check("bp_no_dup", 64'(if8.outValid), 64'(0));

    // Reset with two ops in flight; chained op afterwards sees acc = 0
    if8.inValid = 1'b1;
    if8.opcode = 3'b000; if8.operand1 = 8'hFF; if8.operand2 = 8'h0F;   // -> 0F
    @(negedge clk);
    if8.opcode = 3'b001; if8.operand1 = 8'hF0; if8.operand2 = 8'h00;   // -> F0
    @(negedge clk);
    if8.inValid = 1'b0;
    check("rs_pre_result", 64'(if8.result), 64'(8'h0F));
    #2 rst_n = 1'b0;
    #1;
    check("rs_async_valid", 64'(if8.outValid), 64'(0));
    check("rs_async_result", 64'(if8.result), 64'(0));
    check("rs_async_status", 64'(if8.statusOut), 64'(0));
    check("rs_async_parity", 64'(if8.parity), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    if8.inValid = 1'b1; if8.chain = 1'b1;
    if8.opcode = 3'b001; if8.operand1 = 8'hFF; if8.operand2 = 8'h01;   // acc(0)|01
    @(negedge clk);
    if8.inValid = 1'b0; if8.chain = 1'b0;
    check("rs_discarded", 64'(if8.outValid), 64'(0));
    @(negedge clk);
    check("rs_chain_valid", 64'(if8.outValid), 64'(1));
    check("rs_chain_result", 64'(if8.result), 64'(8'h01));
    check("rs_chain_status", 64'(if8.statusOut), 64'(0));
    check("rs_chain_parity", 64'(if8.parity), 64'(1));

    // Random sweep on the 32-bit units (accumulators were cleared by reset)
    acc_m[0] = 32'd0;
    acc_m[1] = 32'd0;
    rand_run(0, 150, 1'b0);
    rand_run(0, 150, 1'b1);
    rand_run(1, 150, 1'b0);
    rand_run(1, 150, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitlogic_pipe.md
Name: bitlogic_pipe

Overview:
Parametrised, pipelined bitwise-logic unit for the ALU datapath. It executes eight logic operations with an optional accumulate/chain mode, and produces the standard 4-bit ALU status word plus a parity bit. Input and output use valid/ready handshakes, so the unit can sit between the operand-fetch stage and the ALU result mux with backpressure.

Parameters:
WIDTH, 16, operand/result width in bits (legal 2..64)
STAGES, 2, pipeline depth = issue-to-output latency in cycles (legal 1..4)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
inValid  in  1  operand set presented
inReady  out  1  unit accepts operands this cycle
opcode  in  3  operation select (see Behaviour)
chain  in  1  1 = replace operand1 with the accumulator
operand1  in  WIDTH  first operand
operand2  in  WIDTH  second operand
outValid  out  1  result/status valid
outReady  in  1  downstream accepts result
result  out  WIDTH  operation result
statusOut  out  4  status bits at ST_NEG/ST_ZERO/ST_CARRY/ST_OVERFLOW positions of the shared ALU include
parity  out  1  XOR-reduction of result (1 = odd number of ones)

Behaviour:
- Opcodes (A = effective operand1, B = operand2):
  - 000 AND: A&B
  - 001 OR: A|B
  - 010 XOR: A^B
  - 011 NAND: ~(A&B)
  - 100 NOR: ~(A|B)
  - 101 XNOR: ~(A^B)
  - 110 ANDN: A&~B
  - 111 NOT: ~A (B ignored)
- Effective A = chain ? acc : operand1.
- Issue (fire) occurs when inValid && inReady.
- Result, flags and parity are computed combinationally at issue and captured into pipeline stage 1.
- Stages 2..STAGES only delay the stage-1 contents.
- acc (WIDTH bits) is loaded with the computed result on every fire, whether or not chain is set. Chained ops therefore see the immediately preceding issued result, with no hazard regardless of STAGES.
- Flags, all computed from the result:
  - ST_NEG = result[WIDTH-1]
  - ST_ZERO = (result == 0)
  - ST_CARRY = 0
  - ST_OVERFLOW = 0
  - parity = ^result
- Each stage has its own valid bit. Global stall: stall = outValid && !outReady.
- inReady = !stall, a combinational function of outValid and outReady only (no dependence on inValid).
- While stall is high, every stage and acc hold, and no fire occurs.
- When not stalled:
  - stage k+1 takes stage k
  - stage 1 takes the fire data with valid = fire, so bubbles advance as invalid entries
- outValid, result, statusOut and parity are driven from the last stage.
- result/statusOut/parity are don't-care while outValid = 0, but are implemented as the held last-stage contents (no X).
- Latency: an operand accepted at edge N appears with outValid = 1 after edge N+STAGES-1, i.e. visible during cycle N+STAGES when STAGES = 1 means registered-output-next-cycle. Throughput is one op per cycle when outReady stays high.
- Once asserted, outValid and the output data are stable until outReady is seen high.
- Reset (async assert, sync release): all stage valids = 0, all stage data = 0, acc = 0, outValid = 0, result = 0, statusOut = 4'b0000, parity = 0.
- Reset mid-operation discards all in-flight ops and the accumulator. The first op after reset with chain = 1 uses acc = 0.
- Simultaneous output consume and input fire in one cycle is legal, with no bubble inserted.
- Opcode, chain and operands are sampled only on fire. Changes while inValid = 0 or during a stall have no effect.

Test Plan:
1. WIDTH=8, STAGES=2, outReady=1: fire AND 0xF0,0x3C -> 2 cycles later result=0x30, ST_NEG=0, ST_ZERO=0, carry/overflow=0, parity=0.
2. Back-to-back fires XOR 0xAA,0xAA; NAND 0xFF,0x80; NOT 0x7F -> consecutive outputs 0x00 (ST_ZERO=1, parity=0), 0x7F (parity=1), 0x80 (ST_NEG=1, parity=1), one per cycle.
3. Chain: fire OR 0x0F,0x00, then chained AND B=0x3C, then chained ANDN B=0x04 -> outputs 0x0F, 0x0C, 0x08.
4. Backpressure: hold outReady=0 with pipeline full (STAGES=2) -> inReady=0, outValid/result held; a 3rd op presented is not accepted. Release outReady -> all three ops emerge in order, none lost or duplicated.
5. Reset: assert rst_n=0 mid-stream with 2 ops in flight -> outValid=0, result=0, statusOut=0 immediately (asynchronously). After release, chained OR B=0x01 -> result 0x01.
6. Sweep STAGES=1 and 4, WIDTH=32: random ops/stall patterns vs a reference model -> exact result/flags match and latency equals STAGES.
